// File: rtl/rst_sequencer.sv
// rst_sequencer: releases NUM_STAGES reset lines in index order after programmable intervals, then raises done.
module rst_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF_TIME = CNT_W'(2000),
  parameter bit AUTO_START = 1'b1,
  localparam int IDX_W = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  hold,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [CNT_W-1:0]      cfg_dur,
  output logic                  cfg_err,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  done,
  output logic                  busy,
  output logic [IDX_W-1:0]      stage_idx
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] dur [NUM_STAGES+1];
  logic [CNT_W-1:0] cnt, cnt_n, lim;
  logic [IDX_W-1:0] k, k_n, idx_n;
  logic [NUM_STAGES-1:0] srst_n;
  logic done_n, busy_n, acc;
  // comparing against dur-1 keeps dur = 2^CNT_W-1 in range; dur 0 behaves as 1
  assign lim = (dur[k] == '0) ? '0 : dur[k] - CNT_W'(1);
  assign acc = cfg_we && state != WAIT && !abort && cfg_idx <= IDX_W'(NUM_STAGES);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    k_n = k;
    idx_n = stage_idx;
    srst_n = stage_rst;
    done_n = done;
    busy_n = busy;
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      k_n = '0;
      idx_n = '0;
      srst_n = '1;
      done_n = 1'b0;
      busy_n = 1'b0;
    end else if (start && state != WAIT) begin
      state_n = WAIT;
      cnt_n = '0;
      k_n = '0;
      idx_n = '0;
      srst_n = '1;
      done_n = 1'b0;
      busy_n = 1'b1;
    end else if (state == WAIT && !hold) begin
      cnt_n = (cnt == lim) ? '0 : cnt + CNT_W'(1);
      if (cnt == lim && k == IDX_W'(NUM_STAGES)) begin
        state_n = DONE;
        done_n = 1'b1;
        busy_n = 1'b0;
      end else if (cnt == lim) begin
        srst_n = stage_rst & ~(NUM_STAGES'(1) << k);
        k_n = k + IDX_W'(1);
        idx_n = k + IDX_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= AUTO_START ? WAIT : IDLE;
      cnt <= '0;
      k <= '0;
      stage_idx <= '0;
      stage_rst <= '1;
      done <= 1'b0;
      busy <= AUTO_START;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      stage_idx <= idx_n;
      stage_rst <= srst_n;
      done <= done_n;
      busy <= busy_n;
      cfg_err <= cfg_we && !acc;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NUM_STAGES; i++) dur[i] <= DEF_TIME;
    end else if (acc) begin
      dur[cfg_idx] <= cfg_dur;
    end
  end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: randomized and directed checks of rst_sequencer against an elapsed-time reference model.
module tb_rst_sequencer;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 3;
  localparam logic [N+IW+1:0] IDLE_EXP = {4'b1111, 1'b0, 1'b0, 3'd0};
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, hold = 1'b0, cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0] cfg_dur = '0;
  logic cfg_err, done, busy, a_cfg_err, a_done, a_busy;
  logic [N-1:0] stage_rst, a_stage_rst;
  logic [IW-1:0] stage_idx, a_stage_idx;
  logic [N+IW+1:0] obs, exp_v;
  int checks = 0, errors = 0;
  int d [N+1];
  int el;
  logic p;
  assign obs = {stage_rst, done, busy, stage_idx};
  always #5 clk = ~clk;

  rst_sequencer #(.NUM_STAGES(N), .CNT_W(W), .DEF_TIME(32'd4), .AUTO_START(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_dur(cfg_dur), .cfg_err(cfg_err), .stage_rst(stage_rst),
    .done(done), .busy(busy), .stage_idx(stage_idx));
  rst_sequencer #(.NUM_STAGES(N), .CNT_W(W), .DEF_TIME(32'd4), .AUTO_START(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(1'b0), .abort(abort), .hold(hold), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_dur(cfg_dur), .cfg_err(a_cfg_err), .stage_rst(a_stage_rst),
    .done(a_done), .busy(a_busy), .stage_idx(a_stage_idx));

  // number of intervals completed after e effective (unheld) edges
  function automatic int comp(int e);
    int c = 0, s = 0;
    for (int j = 0; j <= N; j++) begin
      s += (d[j] < 1) ? 1 : d[j];
      if (e >= s) c++;
    end
    return c;
  endfunction

  function automatic logic [N+IW+1:0] model(int e);
    int c = comp(e);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = (j >= c);
    return {r, c > N, c <= N, IW'(c > N ? N : c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if (obs !== {4'b1111, 1'b0, 1'b1, 3'd0} || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_auto got %b err=%b exp 1111_0_1_000 err=0", obs, cfg_err);
    end
    checks++;
    if ({a_stage_rst, a_done, a_busy, a_stage_idx} !== IDLE_EXP) begin
      errors++;
      $display("FAIL reset_idle got %b exp %b", {a_stage_rst, a_done, a_busy, a_stage_idx}, IDLE_EXP);
    end
  endtask

  task automatic test_auto;
    int rel0 = -1;
    for (int i = 0; i <= N; i++) d[i] = 4;
    rst = 1'b1;
    el = 0;
    for (int e = 0; e < 24; e++) begin
      p = (comp(el) <= N);
      tick;
      if (p) el++;
      if (rel0 < 0 && !stage_rst[0]) rel0 = e + 1;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL auto edge=%0d got %b exp %b", e + 1, obs, exp_v);
      end
    end
    checks++;
    if (rel0 !== 4) begin
      errors++;
      $display("FAIL auto_first_release got edge %0d exp 4", rel0);
    end
    checks++;
    if ({a_stage_rst, a_done, a_busy, a_stage_idx} !== IDLE_EXP) begin
      errors++;
      $display("FAIL idle_stays got %b exp %b", {a_stage_rst, a_done, a_busy, a_stage_idx}, IDLE_EXP);
    end
  endtask

  task automatic test_program;
    int v [N+1] = '{2, 0, 5, 1, 3};
    int done_at = -1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (obs !== IDLE_EXP) begin
      errors++;
      $display("FAIL abort_to_idle got %b exp %b", obs, IDLE_EXP);
    end
    for (int i = 0; i <= N; i++) begin
      cfg_we = 1'b1;
      cfg_idx = IW'(i);
      cfg_dur = W'(v[i]);
      start = (i == N);
      tick;
      cfg_we = 1'b0;
      start = 1'b0;
      d[i] = v[i];
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL prog_write idx=%0d got err=%b exp 0", i, cfg_err);
      end
    end
    el = 0;
    for (int e = 0; e < 15; e++) begin
      p = (comp(el) <= N);
      tick;
      if (p) el++;
      if (done_at < 0 && done) done_at = e + 1;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL prog edge=%0d got %b exp %b", e + 1, obs, exp_v);
      end
    end
    checks++;
    if (done_at !== 12) begin
      errors++;
      $display("FAIL prog_done_edge got %0d exp 12", done_at);
    end
  endtask

  task automatic test_hold;
    int rel1 = -1;
    for (int i = 0; i <= N; i++) begin
      cfg_we = 1'b1;
      cfg_idx = IW'(i);
      cfg_dur = 32'd4;
      start = (i == N);
      tick;
      d[i] = 4;
    end
    cfg_we = 1'b0;
    start = 1'b0;
    el = 0;
    for (int e = 0; e < 26; e++) begin
      hold = (e >= 6 && e < 9);
      p = !hold && (comp(el) <= N);
      tick;
      if (p) el++;
      if (rel1 < 0 && !stage_rst[1]) rel1 = e + 1;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hold edge=%0d got %b exp %b", e + 1, obs, exp_v);
      end
    end
    hold = 1'b0;
    checks++;
    if (rel1 !== 11) begin
      errors++;
      $display("FAIL hold_release1 got edge %0d exp 11", rel1);
    end
  endtask

  task automatic test_cfg_err;
    start = 1'b1;
    tick;
    start = 1'b0;
    el = 0;
    for (int e = 0; e < 24; e++) begin
      cfg_we = (e == 5);
      cfg_idx = '0;
      cfg_dur = 32'd1;
      p = (comp(el) <= N);
      tick;
      cfg_we = 1'b0;
      if (p) el++;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v || cfg_err !== (e == 5)) begin
        errors++;
        $display("FAIL cfg_wait edge=%0d got %b err=%b exp %b err=%b", e + 1, obs, cfg_err, exp_v, e == 5);
      end
    end
    cfg_we = 1'b1;
    cfg_idx = 3'd5;
    cfg_dur = 32'd1;
    tick;
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL cfg_bad_idx got err=%b done=%b exp err=1 done=1", cfg_err, done);
    end
    tick;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse got %b exp 0", cfg_err);
    end
  endtask

  task automatic test_abort;
    start = 1'b1;
    tick;
    start = 1'b0;
    el = 0;
    for (int e = 0; e < 8; e++) begin
      tick;
      el++;
    end
    checks++;
    if (obs !== model(el) || stage_rst !== 4'b1100) begin
      errors++;
      $display("FAIL abort_pre got %b exp %b", obs, model(el));
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    for (int e = 0; e < 5; e++) begin
      checks++;
      if (obs !== IDLE_EXP) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d got %b exp %b", e, obs, IDLE_EXP);
      end
      tick;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    el = 0;
    for (int e = 0; e < 22; e++) begin
      p = (comp(el) <= N);
      tick;
      if (p) el++;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL restart edge=%0d got %b exp %b", e + 1, obs, exp_v);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    cfg_we = 1'b1;
    cfg_idx = '0;
    cfg_dur = 32'd9;
    tick;
    start = 1'b0;
    abort = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (obs !== IDLE_EXP || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL start_abort got %b err=%b exp %b err=1", obs, cfg_err, IDLE_EXP);
    end
    tick;
    checks++;
    if (obs !== IDLE_EXP) begin
      errors++;
      $display("FAIL start_abort_hold got %b exp %b", obs, IDLE_EXP);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i <= N; i++) begin
        d[i] = int'($urandom_range(0, 5));
        cfg_we = 1'b1;
        cfg_idx = IW'(i);
        cfg_dur = W'(d[i]);
        start = (i == N);
        tick;
      end
      cfg_we = 1'b0;
      start = 1'b0;
      el = 0;
      for (int e = 0; e < 80; e++) begin
        hold = (e < 40) && ($urandom_range(0, 3) == 0);
        start = (comp(el) <= N) && ($urandom_range(0, 7) == 0);
        p = !hold && (comp(el) <= N);
        tick;
        if (p) el++;
        exp_v = model(el);
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL random it=%0d edge=%0d got %b exp %b", it, e + 1, obs, exp_v);
        end
      end
      hold = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i <= N; i++) begin
      d[i] = 1;
      cfg_we = 1'b1;
      cfg_idx = IW'(i);
      cfg_dur = 32'd1;
      start = (i == N);
      tick;
    end
    cfg_we = 1'b0;
    start = 1'b0;
    el = 0;
    for (int e = 0; e < 3; e++) begin
      tick;
      el++;
    end
    checks++;
    if (stage_rst !== 4'b1000 || obs !== model(el)) begin
      errors++;
      $display("FAIL async_pre got %b exp %b", obs, model(el));
    end
    rst = 1'b0;
    #2;
    checks++;
    if (obs !== {4'b1111, 1'b0, 1'b1, 3'd0} || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL async_now got %b err=%b exp 1111_0_1_000 err=0", obs, cfg_err);
    end
    #2;
    rst = 1'b1;
    for (int i = 0; i <= N; i++) d[i] = 4;
    el = 0;
    for (int e = 0; e < 22; e++) begin
      p = (comp(el) <= N);
      tick;
      if (p) el++;
      exp_v = model(el);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL async_after edge=%0d got %b exp %b", e + 1, obs, exp_v);
      end
    end
    checks++;
    if (a_busy !== 1'b0 || a_stage_rst !== 4'b1111) begin
      errors++;
      $display("FAIL async_idle got busy=%b rst=%b exp busy=0 rst=1111", a_busy, a_stage_rst);
    end
  endtask

  initial begin
    test_reset;
    test_auto;
    test_program;
    test_hold;
    test_cfg_err;
    test_abort;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Parametrised power-on/soft reset sequencer. Releases NUM_STAGES downstream active-high reset lines one at a time, in index order (memory, PE array, pooling stages, ...), then raises a final `done` enable, which gates the display.
- Each interval duration is programmable at run time.
- Supports auto-start, restart, pause (hold), abort, and reports its progress.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be ≥1.
- CNT_W, 32: width of duration registers and the interval counter.
- DEF_TIME, 2000: reset value of every duration register, in clk cycles.
- AUTO_START, 1: 1 = the sequence starts on the first clock after `rst` is released; 0 = waits in IDLE for `start`.
- IDX_W, $clog2(NUM_STAGES+1): width of the interval index; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts the sequence from IDLE or DONE.
- abort  in  1  one-cycle pulse; re-asserts all resets and returns to IDLE.
- hold  in  1  level; while high in WAIT, the interval counter is frozen.
- cfg_we  in  1  duration write strobe.
- cfg_idx  in  IDX_W  interval index to write, 0..NUM_STAGES.
- cfg_dur  in  CNT_W  duration value, in cycles.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- stage_rst  out  NUM_STAGES  per-stage reset; 1 = stage held in reset.
- done  out  1  high after all stages are released plus the final interval.
- busy  out  1  high while in WAIT.
- stage_idx  out  IDX_W  current interval index k.

Behaviour:
- States: IDLE, WAIT, DONE.
- Intervals k = 0..NUM_STAGES. Interval k lasts max(dur[k],1) cycles. Without hold, interval k lasts exactly max(dur[k],1) rising edges.
- End of interval k < NUM_STAGES: clear stage_rst[k], increment k, clear the counter, stay in WAIT.
- End of interval NUM_STAGES: set done=1, set busy=0, go to DONE.
- stage_rst[j] is 0 exactly when j < (number of completed intervals).
- All outputs are registered and change only on clock edges or on async reset.
- Async reset (rst=0), which may arrive at any time including mid-sequence:
  - stage_rst=all 1, done=0, cfg_err=0, k=0, counter=0, and all dur[] reset to DEF_TIME.
  - With AUTO_START=1: state=WAIT, busy=1.
  - With AUTO_START=0: state=IDLE, busy=0.
- start in IDLE or DONE: on that edge, state=WAIT, k=0, counter=0, stage_rst=all 1, done=0, busy=1. A start in WAIT is ignored.
- abort in any state: stage_rst=all 1, done=0, busy=0, k=0, counter=0, state=IDLE, independent of AUTO_START.
- Priority when events coincide: abort > start > interval completion.
- hold=1 in WAIT: the counter and all outputs are frozen, and an interval cannot complete. hold has no effect in IDLE or DONE.
- Configuration writes:
  - Accepted only when state is not WAIT and cfg_idx ≤ NUM_STAGES; an accepted write sets dur[cfg_idx] = cfg_dur.
  - A write in the same cycle as start is accepted, and its value is used by the new sequence.
  - A write in the same cycle as abort is rejected.
  - Any rejected write pulses cfg_err for one cycle and leaves dur[] unchanged.
- dur[] persists across start, abort and DONE; only rst restores DEF_TIME.
- stage_idx = k in WAIT, 0 in IDLE, NUM_STAGES in DONE.
- Counter widths: the counter is CNT_W bits and compares against max(dur,1)-1, so dur = 2^CNT_W-1 works without overflow.

Test Plan:
- Auto sequence, NUM_STAGES=4, DEF_TIME=4, AUTO_START=1; release rst.
  - stage_rst = 1111 → 1110 at edge 4 → 1100 at edge 8 → 1000 at edge 12 → 0000 at edge 16.
  - done=1 and busy=0 at edge 20; stage_idx steps 0,1,2,3,4.
- Programmed durations, AUTO_START=0.
  - While in IDLE write dur = {2,0,5,1,3}, then pulse start.
  - Releases at edges 2, 3, 8, 9 after start; done at edge 12 (dur 0 behaves as 1).
- Hold: DEF_TIME=4, assert hold for 3 cycles starting mid-interval 1.
  - stage_rst[1] release is delayed by exactly 3 edges; the other intervals are unchanged.
- Abort and restart.
  - Abort when stage_rst=1100 → next edge stage_rst=1111, busy=0, IDLE, and it stays there.
  - Then start → full sequence repeats with the same dur[].
  - start+abort in the same cycle → IDLE.
- Config rejection.
  - cfg_we during WAIT → cfg_err pulses 1 cycle and timing is unchanged.
  - cfg_idx=5 in DONE → cfg_err pulses and no write occurs.
- Async reset mid-run: drop rst while stage_rst=1000.
  - Immediately stage_rst=1111, done=0, and dur[] returns to DEF_TIME.
  - After release the sequence restarts from interval 0.
